// File: rtl/fifo_pkg.sv
// Shared constants and index-width helper for the write-arbiter slice.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_SRC    = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Latency: zero cycles; backpressure: none, pure function of req and ptr.
module rr_arbiter
    import fifo_pkg::*;
#(
    parameter  int NUM_SRC = DEF_NUM_SRC,
    localparam int IDX_W   = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] cand;

    // Walk the offsets downward so the smallest offset from ptr is the last writer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Merges NUM_SRC single-entry producer ports into one registered FIFO write port.
// Latency: 1 cycle hold to wr_en; backpressure: wr_afull stalls grants, full holds drop s_ready.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int NUM_SRC     = DEF_NUM_SRC,
    parameter  int STALL_CNT_W = 16,
    localparam int IDX_W       = idx_w(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_SRC-1:0]            s_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_data,
    output logic [NUM_SRC-1:0]            s_ready,
    input  logic                          wr_afull,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [IDX_W-1:0]              wr_src,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);

    logic [NUM_SRC-1:0]                 hold_vld_q, hold_vld_d;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic                               wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0]              wr_data_q, wr_data_d;
    logic [IDX_W-1:0]                   wr_src_q, wr_src_d;
    logic [STALL_CNT_W-1:0]             stall_cnt_q, stall_cnt_d;
    logic                               gnt_vld, gnt_fire;
    logic [IDX_W-1:0]                   gnt_idx;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req     (hold_vld_q),
        .ptr     (rr_ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign s_ready  = ~hold_vld_q & {NUM_SRC{~flush}};
    assign gnt_fire = gnt_vld & ~wr_afull & ~flush;

    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        rr_ptr_d    = rr_ptr_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        wr_src_d    = wr_src_q;
        stall_cnt_d = stall_cnt_q;

        // A granted hold has s_ready low, so load and clear never hit the same slot.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (s_valid[i] && s_ready[i]) begin
                hold_vld_d[i]  = 1'b1;
                hold_data_d[i] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (gnt_fire) begin
            hold_vld_d[gnt_idx] = 1'b0;
            wr_en_d             = 1'b1;
            wr_data_d           = hold_data_q[gnt_idx];
            wr_src_d            = gnt_idx;
            rr_ptr_d            = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end

        if ((|hold_vld_q) && wr_afull && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        if (flush) begin
            hold_vld_d = '0;
            rr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= '0;
            rr_ptr_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_src_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_src_q    <= wr_src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Payload is qualified by hold_vld_q, so it carries no reset.
    always_ff @(posedge clk) begin
        hold_data_q <= hold_data_d;
    end

    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign wr_src    = wr_src_q;
    assign stall_cnt = stall_cnt_q;

endmodule
